// File: rtl/pipelined_adder.sv
// ============================================================================
// pipelined_adder
//
// Pipelined add/subtract unit. The WIDTH-bit carry chain is cut into STAGES
// chunks of C = WIDTH/STAGES bits. Each chunk is resolved in its own clock
// stage, so the longest combinational path is one C-bit adder.
//
// Upper operand chunks travel down a skew path until their stage is reached.
// Resolved lower sum chunks travel down a deskew path alongside them. As a
// result, all chunks of one bundle leave the last stage together. The whole
// pipeline advances as one unit whenever the output slot is empty or is being
// consumed, which gives full-rate streaming with backpressure.
//
// Parameters
//   WIDTH      operand / sum width, >= 2, divisible by STAGES
//   STAGES     number of pipeline stages, 1 <= STAGES <= WIDTH
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand bundle valid
//   in_ready   bundle accepted on this edge if in_valid is also high
//   a, b       operands
//   cin        carry-in (borrow-in when sub = 1)
//   sub        0: a + b + cin, 1: a - b - cin
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   s          sum / difference modulo 2^WIDTH
//   cout       carry out of the MSB (for subtraction, 1 = no borrow)
//   ovf        two's-complement signed overflow
// ============================================================================
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int C = WIDTH / STAGES;

    logic             w_en;
    logic [WIDTH-1:0] w_bp;
    logic             w_c0;
    logic             r_ovf;

    // Subtraction is A + ~B + 1. The borrow-in flips the injected carry.
    assign w_bp = sub ? ~b : b;
    assign w_c0 = cin ^ sub;

    // The whole pipeline moves only when the output slot can be refilled.
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en && !rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * C;        // sum bits resolved before this stage
        localparam int HI = (k + 1) * C;  // sum bits resolved after this stage
        localparam int RW = WIDTH - LO;   // operand bits still to be added

        logic [RW-1:0] w_a_in;
        logic [RW-1:0] w_b_in;
        logic          w_c_in;
        logic          w_v_in;
        logic [C:0]    w_chunk;
        logic [HI-1:0] w_sum_next;

        logic          r_v;
        logic          r_c;
        logic [HI-1:0] r_sum;

        if (k == 0) begin : g_head
            assign w_a_in     = a;
            assign w_b_in     = w_bp;
            assign w_c_in     = w_c0;
            assign w_v_in     = in_valid;
            assign w_sum_next = w_chunk[C-1:0];
        end else begin : g_body
            // Skew registers. They hold the operand chunks that the previous
            // stage did not consume.
            logic [RW-1:0] r_a_skew;
            logic [RW-1:0] r_b_skew;

            // NOTE: the skew registers carry no reset. They are only
            // meaningful alongside a set valid bit, and every valid bit is
            // reset. Sequential state uses non-blocking assignments
            // throughout, so stages read their predecessor's old value on
            // the edge.
            always_ff @(posedge clk) begin
                if (w_en) begin
                    r_a_skew <= g_stage[k-1].w_a_in[RW+C-1:C];
                    r_b_skew <= g_stage[k-1].w_b_in[RW+C-1:C];
                end
            end

            assign w_a_in     = r_a_skew;
            assign w_b_in     = r_b_skew;
            assign w_c_in     = g_stage[k-1].r_c;
            assign w_v_in     = g_stage[k-1].r_v;
            assign w_sum_next = {w_chunk[C-1:0], g_stage[k-1].r_sum};
        end

        assign w_chunk = {1'b0, w_a_in[C-1:0]}
                       + {1'b0, w_b_in[C-1:0]}
                       + {{C{1'b0}}, w_c_in};

        always_ff @(posedge clk) begin
            if (rst) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= '0;
            end else if (w_en) begin
                r_v   <= w_v_in;
                r_c   <= w_chunk[C];
                r_sum <= w_sum_next;
            end
        end
    end

    // Signed overflow is evaluated in the last stage. The operand MSBs reach
    // that stage through the skew path, as the top bit of the final chunk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_ovf <= (g_stage[STAGES-1].w_a_in[C-1] == g_stage[STAGES-1].w_b_in[C-1])
                  && (g_stage[STAGES-1].w_chunk[C-1] != g_stage[STAGES-1].w_a_in[C-1]);
        end
    end

    assign out_valid = g_stage[STAGES-1].r_v;
    assign s         = g_stage[STAGES-1].r_sum;
    assign cout      = g_stage[STAGES-1].r_c;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// ============================================================================
// tb_pipelined_adder
//
// Testbench for pipelined_adder. The main instance is WIDTH=16, STAGES=4.
// It covers the reset state, directed vectors with hand-computed results,
// full-rate and randomly stalled streams, and a reset while bundles are in
// flight. Four further instances cover the other (WIDTH, STAGES) corners,
// including latency and back-to-back throughput. Expected values come from
// hand-written tables or from an integer reference model.
// ============================================================================
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
    logic        ovf;

    int n_vec = 0;
    int n_err = 0;
    bit sweep_go = 1'b0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Integer reference model. It returns {ovf, cout, sum[31:0]} for a
    // w-bit operation, using exact signed and unsigned arithmetic.
    function automatic logic [33:0] ref_model(input int w, input logic [31:0] x,
                                              input logic [31:0] y, input logic c,
                                              input logic sb);
        longint md;
        longint ux;
        longint uy;
        longint sx;
        longint sy;
        longint ru;
        longint rs;
        logic   co;
        logic   ov;
        logic [31:0] sum;
        md = longint'(1) << w;
        ux = longint'(x);
        uy = longint'(y);
        sx = x[w-1] ? ux - md : ux;
        sy = y[w-1] ? uy - md : uy;
        if (sb) begin
            ru = ux - uy - longint'(c);
            rs = sx - sy - longint'(c);
            co = (ru >= 0);
        end else begin
            ru = ux + uy + longint'(c);
            rs = sx + sy + longint'(c);
            co = (ru >= md);
        end
        ov  = (rs >= md / 2) || (rs < -(md / 2));
        sum = 32'(ru & (md - 1));
        return {ov, co, sum};
    endfunction

    // Sends one bundle into an empty pipeline and returns the result and
    // the latency, counted from the acceptance edge.
    task automatic single_op(input logic [15:0] ta, input logic [15:0] tb_v,
                             input logic tc, input logic ts,
                             output logic [17:0] res, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; sub = ts;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
        end
        res = {ovf, cout, s};
        @(posedge clk);
    endtask

    // Streams n random bundles. Each cycle, out_ready is high with
    // probability pct. The task checks ordering, handshake, hold and count.
    task automatic run_stream(input int n, input int pct, input string tag);
        logic [33:0] q[$];
        logic [33:0] e;
        logic [17:0] held;
        logic        stall_prev;
        bit          take;
        int          sent;
        int          got;
        int          first_c;
        int          last_c;
        sent = 0; got = 0; first_c = -1; last_c = -1;
        stall_prev = 1'b0; take = 1'b1; held = '0;
        for (int c = 0; c < n * 8 + 50 && got < n; c++) begin
            @(negedge clk);
            if (stall_prev) check({tag, "_hold"}, {ovf, cout, s}, held);
            if (take) begin
                if (sent < n) begin
                    a = 16'($urandom); b = 16'($urandom);
                    cin = 1'($urandom); sub = 1'($urandom);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(99) < pct);
            #1;
            check({tag, "_in_ready"}, in_ready, !(out_valid && !out_ready));
            take = in_valid && in_ready;
            if (take) begin
                q.push_back(ref_model(16, 32'(a), 32'(b), cin, sub));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check({tag, "_dup"}, 1, 0);
                end else begin
                    e = q.pop_front();
                    check({tag, "_result"}, {ovf, cout, s}, {e[33:32], e[15:0]});
                end
                got++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            stall_prev = out_valid && !out_ready;
            held = {ovf, cout, s};
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_count"}, got, n);
        check({tag, "_left"}, q.size(), 0);
        if (pct >= 100) check({tag, "_gap"}, last_c - first_c + 1, n);
    endtask

    // Parameter sweep instances: a latency probe and a back-to-back stream.
    for (genvar gi = 0; gi < 4; gi++) begin : g_sw
        localparam int W = (gi == 0) ? 4 : (gi == 1) ? 8 : (gi == 2) ? 32 : 16;
        localparam int S = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 8 : 16;

        logic         sw_rst;
        logic         sw_iv;
        logic         sw_ir;
        logic [W-1:0] sw_a;
        logic [W-1:0] sw_b;
        logic         sw_ci;
        logic         sw_sb;
        logic         sw_ov;
        logic         sw_or;
        logic [W-1:0] sw_s;
        logic         sw_co;
        logic         sw_of;
        bit           done = 1'b0;

        pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk       (clk),
            .rst       (sw_rst),
            .in_valid  (sw_iv),
            .in_ready  (sw_ir),
            .a         (sw_a),
            .b         (sw_b),
            .cin       (sw_ci),
            .sub       (sw_sb),
            .out_valid (sw_ov),
            .out_ready (sw_or),
            .s         (sw_s),
            .cout      (sw_co),
            .ovf       (sw_of)
        );

        initial begin : p_run
            logic [33:0] q[$];
            logic [33:0] e;
            int          lat;
            int          got;
            int          first_c;
            int          last_c;
            string       tag;
            tag = $sformatf("sw_w%0d_s%0d", W, S);
            sw_rst = 1'b1; sw_iv = 1'b0; sw_or = 1'b1;
            sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sb = 1'b0;
            wait (sweep_go);
            repeat (2) @(posedge clk);
            @(negedge clk);
            sw_rst = 1'b0;
            #1;
            check({tag, "_rst_valid"}, sw_ov, 0);
            check({tag, "_rst_ready"}, sw_ir, 1);

            sw_a = W'($urandom); sw_b = W'($urandom);
            sw_ci = 1'($urandom); sw_sb = 1'($urandom);
            sw_iv = 1'b1;
            e = ref_model(W, 32'(sw_a), 32'(sw_b), sw_ci, sw_sb);
            @(posedge clk);
            #1 sw_iv = 1'b0;
            lat = 1;
            while (lat < S + 10) begin
                @(negedge clk);
                if (sw_ov) break;
                lat++;
            end
            check({tag, "_latency"}, lat, S);
            check({tag, "_first"}, {sw_of, sw_co, sw_s}, {e[33:32], e[W-1:0]});
            @(posedge clk);

            got = 0; first_c = -1; last_c = -1;
            for (int c = 0; c < 40 + S + 10; c++) begin
                @(negedge clk);
                if (c < 40) begin
                    sw_a = W'($urandom); sw_b = W'($urandom);
                    sw_ci = 1'($urandom); sw_sb = 1'($urandom);
                    sw_iv = 1'b1;
                end else begin
                    sw_iv = 1'b0;
                end
                #1;
                if (sw_iv && sw_ir) q.push_back(ref_model(W, 32'(sw_a), 32'(sw_b), sw_ci, sw_sb));
                if (sw_ov) begin
                    if (q.size() == 0) begin
                        check({tag, "_dup"}, 1, 0);
                    end else begin
                        e = q.pop_front();
                        check({tag, "_result"}, {sw_of, sw_co, sw_s}, {e[33:32], e[W-1:0]});
                    end
                    got++;
                    if (first_c < 0) first_c = c;
                    last_c = c;
                end
            end
            check({tag, "_count"}, got, 40);
            check({tag, "_gap"}, last_c - first_c + 1, 40);
            done = 1'b1;
        end
    end

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t dir_vec [9];

    initial begin : p_main
        logic [17:0] res;
        int          lat;
        int          stale;
        bit          all_done;

        //                a         b         cin   sub   s         co    ov
        dir_vec[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        dir_vec[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        dir_vec[2] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        dir_vec[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        dir_vec[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        dir_vec[5] = '{16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
        dir_vec[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        dir_vec[7] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        dir_vec[8] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 9; i++) begin
            single_op(dir_vec[i].a, dir_vec[i].b, dir_vec[i].cin, dir_vec[i].sub, res, lat);
            check($sformatf("dir%0d_result", i), res, {dir_vec[i].ov, dir_vec[i].co, dir_vec[i].s});
            check($sformatf("dir%0d_latency", i), lat, 4);
        end

        run_stream(100, 100, "stream");
        run_stream(150, 50, "bp");

        // Reset with three bundles in flight. Inputs stay active during reset.
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        a = 16'h1111; b = 16'h2222;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_s", s, 0);
        check("mid_rst_cout", cout, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_in_ready_after", in_ready, 1);
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("mid_rst_stale", stale, 0);
        single_op(16'h4321, 16'h1234, 1'b1, 1'b0, res, lat);
        check("post_rst_result", res, {1'b0, 1'b0, 16'h5556});
        check("post_rst_latency", lat, 4);

        sweep_go = 1'b1;
        all_done = 1'b0;
        for (int i = 0; i < 5000 && !all_done; i++) begin
            @(posedge clk);
            all_done = g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done;
        end
        check("sweep_done", all_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined successor to the team's 4-bit ripple-carry adder. It adds or subtracts two WIDTH-bit operands with carry-in, splitting the carry chain into STAGES registered chunks so that wide adders close timing. Operands enter and results leave through a valid/ready handshake with full backpressure. It sits in datapaths (accumulators, address generators) that need WIDTH ≥ 16 at full clock rate.

## Interface
- WIDTH, 16, operand and sum width in bits; must be ≥ 2 and divisible by STAGES.
- STAGES, 4, number of pipeline stages; chunk width C = WIDTH/STAGES; 1 ≤ STAGES ≤ WIDTH.
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (borrow-in when sub=1).
- sub  in  1  0 = A+B+cin; 1 = A−B−cin.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- s  out  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  out  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.

## Operation
- Effective operands: B' = sub ? ~b : b; c0 = cin ^ sub. Result = A + B' + c0 (WIDTH+1 bits; MSB is cout).
- Stage k (0..STAGES−1) adds chunk k of A and B' (bits [k·C +: C]) plus the carry registered by stage k−1 (stage 0 uses c0), registers C sum bits and its carry-out.
- Upper operand chunks are delayed by k cycles in skew registers before stage k; lower sum chunks are delayed by STAGES−1−k cycles in deskew registers, so all chunks of one bundle leave together.
- ovf = (A[MSB] == B'[MSB]) && (s[MSB] != A[MSB]), computed in the last stage with A/B' MSBs carried along the skew path.
- Each stage carries a valid bit; bubbles propagate as invalid slots.
- Global advance enable en = !out_valid || out_ready. When en=0, every pipeline register (data, carries, valids) holds.
- in_ready = en && !rst. A bundle is accepted when in_valid && in_ready at a clock edge. A result is consumed when out_valid && out_ready.
- When en=1 and in_valid=0, an invalid slot enters stage 0.
- Reset: all valid bits, s, cout and ovf clear to 0 on the edge where rst=1. In-flight bundles are discarded. Inputs are ignored while rst=1.
- There is no other state; the block has no FSM beyond the valid shift chain.

## Timing
- Latency: a bundle accepted at edge t appears with out_valid=1 after edge t+STAGES−1. The result is registered from the last stage, so STAGES=1 gives 1 cycle and STAGES=4 gives 4 cycles, measured from acceptance to the first cycle out_valid is high.
- Throughput: 1 bundle/cycle while out_ready=1.
- Stall: out_valid=1 and out_ready=0 → in_ready=0 in the same cycle (combinational). s, cout and ovf are held stable until consumed.
- Simultaneous consume and accept in one cycle is legal and required; there is no bubble.
- out_ready with out_valid=0 has no effect.
- Output ports are driven directly from registers. The only combinational input-to-output path is out_ready → in_ready.
- Deasserting rst: in_ready=1 in the first cycle after the reset edge. out_valid stays 0 until the first accepted bundle has traversed.

## Test plan
- Add with carry (WIDTH=16, STAGES=4): a=0xFFFF, b=0x0001, cin=0, sub=0 → after 4 cycles s=0x0000, cout=1, ovf=0. This exercises cross-chunk carry through all stages.
- Subtract and overflow: a=0x8000, b=0x0001, sub=1, cin=0 → s=0x7FFF, cout=1, ovf=1. Then a=0x0003, b=0x0005, sub=1 → s=0xFFFE, cout=0, ovf=0.
- Streaming: 100 random back-to-back bundles with out_ready=1 → one result per cycle, in order, each matching (a ± b ± cin) mod 2^16, with cout and ovf matching a 17-bit reference model.
- Backpressure: stream with out_ready toggled randomly (about 50%) → no result lost or duplicated, s held stable while stalled, in_ready=0 exactly when out_valid && !out_ready.
- Reset mid-stream: assert rst for 1 cycle with 3 bundles in flight → out_valid=0 and s=0 next cycle, no stale result ever emerges, a new bundle accepted after reset returns the correct sum 4 cycles later.
- Parameter sweep: repeat the random stream for (WIDTH, STAGES) = (4,1), (8,2), (32,8), (16,16) → all results match the reference model, and measured latency equals STAGES.
